// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86 register index constants shared by decode, regfile and write-back
//
// Purpose: named architectural register indices, the "no register" index and
// the %rsp reset value. Register index type is 4 bits (RNONE = 4'hF).
// Ports: none (package).

package y86_pkg;

  typedef logic [3:0] reg_idx_t;

  localparam reg_idx_t RAX   = 4'd0;
  localparam reg_idx_t RCX   = 4'd1;
  localparam reg_idx_t RDX   = 4'd2;
  localparam reg_idx_t RBX   = 4'd3;
  localparam reg_idx_t RSP   = 4'd4;
  localparam reg_idx_t RBP   = 4'd5;
  localparam reg_idx_t RSI   = 4'd6;
  localparam reg_idx_t RDI   = 4'd7;
  localparam reg_idx_t R8    = 4'd8;
  localparam reg_idx_t R9    = 4'd9;
  localparam reg_idx_t R10   = 4'd10;
  localparam reg_idx_t R11   = 4'd11;
  localparam reg_idx_t R12   = 4'd12;
  localparam reg_idx_t R13   = 4'd13;
  localparam reg_idx_t R14   = 4'd14;
  localparam reg_idx_t RNONE = 4'd15;

  // Stack grows down from SP_INIT-1.
  localparam int SP_INIT = 1024;

endpackage

// File: rtl/y86_regfile_pipe_if.sv
// rtl/y86_regfile_pipe_if.sv - decode/write-back bus of the PIPE register file
//
// Purpose: groups the read port (srcA/srcB, rd_en, valA/valB, busyA/busyB),
// the write-back port (wr_en, dstE/dstM, valE/valM), the decode claim port
// (claim_en, claim_dstE/claim_dstM) and the sticky regerr flag.
// Modports: master = pipeline stages driving the regfile, slave = regfile.

interface y86_regfile_pipe_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4
);

  logic [ADDR_W-1:0] srcA;
  logic [ADDR_W-1:0] srcB;
  logic              rd_en;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic              busyA;
  logic              busyB;

  logic              wr_en;
  logic [ADDR_W-1:0] dstE;
  logic [ADDR_W-1:0] dstM;
  logic [DATA_W-1:0] valE;
  logic [DATA_W-1:0] valM;

  logic              claim_en;
  logic [ADDR_W-1:0] claim_dstE;
  logic [ADDR_W-1:0] claim_dstM;

  logic              regerr;

  modport master (
    output srcA, srcB, rd_en, wr_en, dstE, dstM, valE, valM,
           claim_en, claim_dstE, claim_dstM,
    input  valA, valB, busyA, busyB, regerr
  );

  modport slave (
    input  srcA, srcB, rd_en, wr_en, dstE, dstM, valE, valM,
           claim_en, claim_dstE, claim_dstM,
    output valA, valB, busyA, busyB, regerr
  );

endinterface

// File: rtl/y86_pend_ctr.sv
// rtl/y86_pend_ctr.sv - saturating pending-write counter for one register
//
// Purpose: counts outstanding claimed writes for a single register.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   i_inc        a claim on this register this cycle
//   i_dec        a write-back to this register this cycle
//   o_count      current pending count
//   o_ovf        increment attempted at max (count held)
//   o_unf        decrement attempted at 0 (count held)

module y86_pend_ctr #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [PEND_W-1:0] o_count,
  output logic              o_ovf,
  output logic              o_unf
);

  localparam logic [PEND_W-1:0] L_MAX = '1;

  logic [PEND_W-1:0] r_count;
  logic [PEND_W-1:0] w_next;

  // A claim and a retire on the same register in one cycle cancel, so
  // neither can raise an error even at the saturation points.
  always_comb begin
    w_next = r_count;
    o_ovf  = 1'b0;
    o_unf  = 1'b0;
    if (i_inc && !i_dec) begin
      if (r_count == L_MAX) begin
        o_ovf = 1'b1;
      end else begin
        w_next = r_count + 1'b1;
      end
    end else if (i_dec && !i_inc) begin
      if (r_count == '0) begin
        o_unf = 1'b1;
      end else begin
        w_next = r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/y86_regfile_pipe.sv
// rtl/y86_regfile_pipe.sv - Y86 PIPE register file with bypass and pending-write scoreboard
//
// Purpose: NREGS x DATA_W architectural registers, two combinational read
// ports with same-cycle write-through, and per-register pending-write counters
// so decode can see load/use and data hazards (busyA/busyB).
// Ports:
//   clk     rising-edge clock
//   reset   synchronous active-low reset
//   bus     y86_regfile_pipe_if.slave: read, write-back, claim ports, regerr

module y86_regfile_pipe
  import y86_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int NREGS   = 15,
  parameter int ADDR_W  = 4,
  parameter int SP_IDX  = int'(RSP),
  parameter int SP_INIT = y86_pkg::SP_INIT,
  parameter int PEND_W  = 2,
  parameter int BYPASS  = 1
) (
  input  logic                clk,
  input  logic                reset,
  y86_regfile_pipe_if.slave   bus
);

  localparam logic [ADDR_W-1:0] L_RNONE = '1;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              r_regerr;

  logic [PEND_W-1:0] w_pend [NREGS];
  logic [NREGS-1:0]  w_inc;
  logic [NREGS-1:0]  w_dec;
  logic [NREGS-1:0]  w_ovf;
  logic [NREGS-1:0]  w_unf;

  logic [DATA_W-1:0] w_valA;
  logic [DATA_W-1:0] w_valB;
  logic              w_busyA;
  logic              w_busyB;
  logic              w_idx_err;
  logic              w_err_now;

  function automatic logic idx_ok(input logic [ADDR_W-1:0] idx);
    return int'(idx) < NREGS;
  endfunction

  // Indices between the last real register and RNONE address nothing.
  function automatic logic idx_bad(input logic [ADDR_W-1:0] idx);
    return !idx_ok(idx) && (idx != L_RNONE);
  endfunction

  // Register array. When both write ports hit the same register the M value
  // wins, which gives popq %rsp its architectural result.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (!reset) begin
        r_regs[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
      end else if (bus.wr_en) begin
        if (bus.dstM == ADDR_W'(i)) begin
          r_regs[i] <= bus.valM;
        end else if (bus.dstE == ADDR_W'(i)) begin
          r_regs[i] <= bus.valE;
        end
      end
    end
  end

  // One pending counter per register. A port hitting the same register on
  // both E and M counts as a single event.
  for (genvar g = 0; g < NREGS; g++) begin : g_pend
    assign w_inc[g] = bus.claim_en &&
                      ((bus.claim_dstE == ADDR_W'(g)) || (bus.claim_dstM == ADDR_W'(g)));
    assign w_dec[g] = bus.wr_en &&
                      ((bus.dstE == ADDR_W'(g)) || (bus.dstM == ADDR_W'(g)));

    y86_pend_ctr #(
      .PEND_W (PEND_W)
    ) u_pend_ctr (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_inc[g]),
      .i_dec   (w_dec[g]),
      .o_count (w_pend[g]),
      .o_ovf   (w_ovf[g]),
      .o_unf   (w_unf[g])
    );
  end

  // Read port A: array value, overridden by the write port when bypass is on.
  always_comb begin
    w_valA = '0;
    if (reset && bus.rd_en && idx_ok(bus.srcA)) begin
      if ((BYPASS != 0) && bus.wr_en && (bus.srcA == bus.dstM)) begin
        w_valA = bus.valM;
      end else if ((BYPASS != 0) && bus.wr_en && (bus.srcA == bus.dstE)) begin
        w_valA = bus.valE;
      end else begin
        w_valA = r_regs[bus.srcA];
      end
    end
  end

  always_comb begin
    w_valB = '0;
    if (reset && bus.rd_en && idx_ok(bus.srcB)) begin
      if ((BYPASS != 0) && bus.wr_en && (bus.srcB == bus.dstM)) begin
        w_valB = bus.valM;
      end else if ((BYPASS != 0) && bus.wr_en && (bus.srcB == bus.dstE)) begin
        w_valB = bus.valE;
      end else begin
        w_valB = r_regs[bus.srcB];
      end
    end
  end

  // Busy: a write is still outstanding, unless the last one is being
  // forwarded to the read port right now.
  always_comb begin
    w_busyA = 1'b0;
    if (reset && idx_ok(bus.srcA) && (w_pend[bus.srcA] != '0)) begin
      w_busyA = !((BYPASS != 0) && bus.wr_en &&
                  (w_pend[bus.srcA] == PEND_W'(1)) &&
                  ((bus.srcA == bus.dstE) || (bus.srcA == bus.dstM)));
    end
  end

  always_comb begin
    w_busyB = 1'b0;
    if (reset && idx_ok(bus.srcB) && (w_pend[bus.srcB] != '0)) begin
      w_busyB = !((BYPASS != 0) && bus.wr_en &&
                  (w_pend[bus.srcB] == PEND_W'(1)) &&
                  ((bus.srcB == bus.dstE) || (bus.srcB == bus.dstM)));
    end
  end

  // Only indices that the cycle actually uses are checked.
  assign w_idx_err = (bus.rd_en    && (idx_bad(bus.srcA)       || idx_bad(bus.srcB)))       ||
                     (bus.wr_en    && (idx_bad(bus.dstE)       || idx_bad(bus.dstM)))       ||
                     (bus.claim_en && (idx_bad(bus.claim_dstE) || idx_bad(bus.claim_dstM)));

  assign w_err_now = (|w_ovf) || (|w_unf) || w_idx_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_regerr <= 1'b0;
    end else if (w_err_now) begin
      r_regerr <= 1'b1;
    end
  end

  assign bus.valA   = w_valA;
  assign bus.valB   = w_valB;
  assign bus.busyA  = w_busyA;
  assign bus.busyB  = w_busyB;
  assign bus.regerr = r_regerr;

endmodule

// File: tb/tb_y86_regfile_pipe.sv
// tb/tb_y86_regfile_pipe.sv - scoreboard bench for y86_regfile_pipe

module tb_y86_regfile_pipe;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  y86_regfile_pipe_if bus ();

  y86_regfile_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] va;
    logic [63:0] vb;
    logic        ba;
    logic        bb;
    logic        err;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural state only.
  logic [63:0] m_regs [15];
  int          m_pend [15];
  bit          m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 15; i++) begin
      m_regs[i] = (i == 4) ? 64'd1024 : 64'd0;
      m_pend[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic logic [63:0] exp_val(input logic [3:0] s);
    if (!reset || !bus.rd_en || s == 4'hF) return 64'd0;
    if (bus.wr_en && bus.dstM == s) return bus.valM;
    if (bus.wr_en && bus.dstE == s) return bus.valE;
    return m_regs[s];
  endfunction

  function automatic logic exp_busy(input logic [3:0] s);
    if (!reset || s == 4'hF) return 1'b0;
    if (m_pend[s] == 0) return 1'b0;
    if (bus.wr_en && m_pend[s] == 1 && (s == bus.dstE || s == bus.dstM)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_clock();
    bit inc, dec;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 15; i++) begin
      inc = bus.claim_en && (bus.claim_dstE == 4'(i) || bus.claim_dstM == 4'(i));
      dec = bus.wr_en && (bus.dstE == 4'(i) || bus.dstM == 4'(i));
      if (inc && !dec) begin
        if (m_pend[i] == 3) m_err = 1'b1;
        else m_pend[i]++;
      end else if (dec && !inc) begin
        if (m_pend[i] == 0) m_err = 1'b1;
        else m_pend[i]--;
      end
    end
    if (bus.wr_en) begin
      if (bus.dstE != 4'hF) m_regs[bus.dstE] = bus.valE;
      if (bus.dstM != 4'hF) m_regs[bus.dstM] = bus.valM;
    end
  endfunction

  task automatic drive(input logic rd, input logic [3:0] sa, input logic [3:0] sb,
                       input logic wr, input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm,
                       input logic cl, input logic [3:0] ce, input logic [3:0] cm);
    bus.rd_en = rd; bus.srcA = sa; bus.srcB = sb;
    bus.wr_en = wr; bus.dstE = de; bus.valE = ve; bus.dstM = dm; bus.valM = vm;
    bus.claim_en = cl; bus.claim_dstE = ce; bus.claim_dstM = cm;
  endtask

  // Inputs are already applied just after a posedge; expectations are queued
  // and the monitor compares them at the following negedge.
  task automatic step(input string tag);
    exp_t e;
    e.va  = exp_val(bus.srcA);
    e.vb  = exp_val(bus.srcB);
    e.ba  = exp_busy(bus.srcA);
    e.bb  = exp_busy(bus.srcB);
    e.err = m_err;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".valA"},   bus.valA,          e.va);
      chk({t, ".valB"},   bus.valB,          e.vb);
      chk({t, ".busyA"},  64'(bus.busyA),    64'(e.ba));
      chk({t, ".busyB"},  64'(bus.busyB),    64'(e.bb));
      chk({t, ".regerr"}, 64'(bus.regerr),   64'(e.err));
    end
  end

  function automatic logic [3:0] pick_pending();
    int cand[$];
    for (int i = 0; i < 15; i++) if (m_pend[i] > 0) cand.push_back(i);
    if (cand.size() == 0) return 4'hF;
    return 4'(cand[$urandom_range(0, cand.size() - 1)]);
  endfunction

  function automatic logic [3:0] rand_idx();
    return ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 14));
  endfunction

  localparam logic [3:0] N = 4'hF;

  initial begin
    model_reset();
    reset = 1'b0;
    drive(0, N, N, 0, N, 0, N, 0, 0, N, N);
    @(posedge clk);
    #1;

    // Reset held two cycles, then initial contents.
    step("rst1");
    step("rst2");
    reset = 1'b1;
    drive(1, 4, 0, 0, N, 0, N, 0, 0, N, N);
    step("reset_val");

    // Write then read, same-cycle bypass.
    drive(1, 3, N, 0, N, 0, N, 0, 1, 3, N);
    step("claim3");
    drive(1, 3, N, 1, 3, 64'h55, N, 0, 0, N, N);
    step("wr_bypass");
    drive(1, 3, 4, 0, N, 0, N, 0, 0, N, N);
    step("wr_read");

    // E/M collision: M wins.
    drive(1, 4, N, 0, N, 0, N, 0, 1, 4, 4);
    step("claim4");
    drive(1, 4, N, 1, 4, 64'd1016, 4, 64'd2000, 0, N, N);
    step("coll_bypass");
    drive(1, 4, N, 0, N, 0, N, 0, 0, N, N);
    step("coll_read");

    // Two claims on reg 2, drained by two writes.
    drive(1, 2, N, 0, N, 0, N, 0, 1, 2, N);
    step("claim2a");
    step("claim2b");
    drive(1, 2, N, 0, N, 0, N, 0, 0, N, N);
    step("busy2");
    drive(1, 2, N, 1, 2, 64'h111, N, 0, 0, N, N);
    step("wr2a");
    drive(1, 2, N, 1, 2, 64'h222, N, 0, 0, N, N);
    step("wr2b");
    drive(1, 2, N, 0, N, 0, N, 0, 0, N, N);
    step("idle2");

    // Underflow: sticky until reset.
    drive(1, 5, N, 1, 5, 64'd7, N, 0, 0, N, N);
    step("unf5");
    drive(1, 5, N, 0, N, 0, N, 0, 0, N, N);
    step("sticky1");
    step("sticky2");
    reset = 1'b0;
    step("err_rst");
    reset = 1'b1;
    step("err_clear");

    // Overflow on reg 6: saturates at 3, so three writes drain it.
    drive(1, 6, N, 0, N, 0, N, 0, 1, 6, N);
    for (int k = 0; k < 4; k++) step("ovf6_claim");
    drive(1, 6, N, 0, N, 0, N, 0, 0, N, N);
    step("ovf6_busy");
    for (int k = 0; k < 3; k++) begin
      drive(1, 6, 6, 1, 6, 64'(k + 100), N, 0, 0, N, N);
      step("drain6");
    end
    drive(1, 6, 6, 0, N, 0, N, 0, 0, N, N);
    step("drained6");

    // Mid-operation reset with claims outstanding.
    reset = 1'b0;
    step("pre_mid_rst");
    reset = 1'b1;
    drive(1, 7, 8, 0, N, 0, N, 0, 1, 7, 8);
    step("mid_claim1");
    step("mid_claim2");
    drive(1, 7, 1, 1, 1, 64'd99, N, 0, 0, N, N);
    step("mid_wr1");
    reset = 1'b0;
    drive(1, 7, 1, 0, N, 0, N, 0, 0, N, N);
    step("mid_rst");
    reset = 1'b1;
    step("mid_after");
    drive(1, 4, 8, 0, N, 0, N, 0, 0, N, N);
    step("mid_sp");

    // Randomised traffic with periodic resets.
    for (int c = 0; c < 600; c++) begin
      logic [3:0] de, dm;
      reset = ((c % 60) == 59) ? 1'b0 : 1'b1;
      de = ($urandom_range(0, 3) != 0) ? pick_pending() : rand_idx();
      dm = ($urandom_range(0, 2) == 0) ? pick_pending() : N;
      drive($urandom_range(0, 9) != 0, rand_idx(), rand_idx(),
            $urandom_range(0, 1) == 1, de, {$urandom, $urandom}, dm, {$urandom, $urandom},
            $urandom_range(0, 2) == 0, rand_idx(), ($urandom_range(0, 3) == 0) ? rand_idx() : N);
      step("rand");
    end

    drive(0, N, N, 0, N, 0, N, 0, 0, N, N);
    @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
